// File: rtl/decoder_3to8_pulse_if.sv
// Handshake and output bundle for decoder_3to8_pulse.
// The master side offers codes and watches the strobe; the slave side is the decoder.
interface decoder_3to8_pulse_if;
    logic       en;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic [7:0] y;
    logic       y_valid;
    logic       busy;

    modport master (
        output en, in_valid, in_code,
        input  in_ready, y, y_valid, busy
    );

    modport slave (
        input  en, in_valid, in_code,
        output in_ready, y, y_valid, busy
    );
endinterface

// File: rtl/decoder_3to8_pulse.sv
// Registered 3-to-8 one-hot decoder with a valid/ready input and a timed output hold.
// Each accepted code drives y = 1 << code for HOLD_CYCLES clocks, then y returns to zero.
// A new code can be taken on the last hold cycle, so back-to-back codes leave no gap.
// Optional macro DEC_RETRIGGER_EN: a code may be accepted at any point of a hold,
// replacing the output and restarting the hold time.
module decoder_3to8_pulse #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    decoder_3to8_pulse_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Counter value loaded on accept; the hold ends on the cycle where cnt reads 0.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       y_q,     y_d;
    logic             y_valid_q, y_valid_d;
    logic             busy_q,  busy_d;

    logic ready;
    logic accept;

`ifdef DEC_RETRIGGER_EN
    // Any cycle with enable set can take a code, restarting the hold.
    assign ready = bus.en;
`else
    // A new code is taken when idle, or on the final cycle of the current hold.
    assign ready = bus.en && ((state_q == IDLE) || ((state_q == HOLD) && (cnt_q == '0)));
`endif

    assign accept = bus.in_valid && ready;

    // Next-state, hold counter and output computation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        busy_d    = busy_q;

        if (accept) begin
            state_d   = HOLD;
            cnt_d     = HOLD_LOAD;
            y_d       = 8'b1 << bus.in_code;
            y_valid_d = 1'b1;
            busy_d    = 1'b1;
        end else if (state_q == HOLD) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d   = IDLE;
                y_d       = '0;
                y_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        end
    end

    // State and output registers; reset wins over everything, including a hold in progress.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.in_ready = ready;
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Self-checking bench for decoder_3to8_pulse.
// Two instances share one stimulus stream: dut0 with HOLD_CYCLES=4, dut1 with HOLD_CYCLES=1.
// A cycle model per instance pushes expected outputs to a queue before each edge;
// the entries are popped and compared at the following falling edge.
module tb_decoder_3to8_pulse;

    typedef struct packed {
        logic [7:0] y;
        logic       y_valid;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_v = 1'b1;
    logic       en_v = 1'b1;
    logic       valid_v = 1'b0;
    logic [2:0] code_v = 3'd0;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: remaining visible cycles of the current code (0 = idle).
    int   m_rem  [2];
    int   m_code [2];
    int   m_hold [2];
    bit   m_known = 1'b0;
    exp_t q0 [$];
    exp_t q1 [$];

    // Expected dut0 observations for the back-to-back scenario.
    logic [7:0] b2b_y   [9] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
    logic [7:0] hold_y  [5] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
    logic       hold_rd [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    decoder_3to8_pulse_if bus0 ();
    decoder_3to8_pulse_if bus1 ();

    assign bus0.en       = en_v;
    assign bus0.in_valid = valid_v;
    assign bus0.in_code  = code_v;
    assign bus1.en       = en_v;
    assign bus1.in_valid = valid_v;
    assign bus1.in_code  = code_v;

    decoder_3to8_pulse #(.HOLD_CYCLES(4), .CNT_W(8)) dut0 (
        .clk (clk),
        .rst (rst_v),
        .bus (bus0)
    );

    decoder_3to8_pulse #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst_v),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int i);
`ifdef DEC_RETRIGGER_EN
        return en_v;
`else
        return en_v && (m_rem[i] <= 1);
`endif
    endfunction

    function automatic exp_t exp_out(input int i);
        exp_t e;
        e.y       = (m_rem[i] > 0) ? (8'd1 << m_code[i]) : 8'h00;
        e.y_valid = (m_rem[i] > 0);
        e.busy    = (m_rem[i] > 0);
        return e;
    endfunction

    // Advance the model of instance i across the coming edge using the driven inputs.
    task automatic model_step(input int i);
        if (rst_v) begin
            m_rem[i] = 0;
        end else if (valid_v && exp_ready(i)) begin
            m_code[i] = int'(code_v);
            m_rem[i]  = m_hold[i];
        end else if (m_rem[i] > 0) begin
            m_rem[i] = m_rem[i] - 1;
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, predict, cross the rising edge.
    task automatic cycle(input logic r, input logic e, input logic v, input logic [2:0] c);
        exp_t got;
        exp_t want;
        rst_v   = r;
        en_v    = e;
        valid_v = v;
        code_v  = c;
        @(negedge clk);
        if (q0.size() > 0) begin
            want = q0.pop_front();
            got  = '{bus0.y, bus0.y_valid, bus0.busy};
            check("dut0_out", 32'(got), 32'(want));
        end
        if (q1.size() > 0) begin
            want = q1.pop_front();
            got  = '{bus1.y, bus1.y_valid, bus1.busy};
            check("dut1_out", 32'(got), 32'(want));
        end
        if (m_known) begin
            check("dut0_ready", 32'(bus0.in_ready), 32'(exp_ready(0)));
            check("dut1_ready", 32'(bus1.in_ready), 32'(exp_ready(1)));
        end
        if (r) m_known = 1'b1;
        if (m_known) begin
            model_step(0);
            model_step(1);
            q0.push_back(exp_out(0));
            q1.push_back(exp_out(1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_hold[0] = 4;
        m_hold[1] = 1;
        m_rem     = '{0, 0};
        m_code    = '{0, 0};

        // Reset held two cycles while a code is offered.
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 3'd5);
            check("rst_y", 32'(bus0.y), 32'h0);
            check("rst_busy", 32'(bus0.busy), 32'h0);
        end
        cycle(1'b0, 1'b1, 1'b0, 3'd0);
        check("post_rst_ready", 32'(bus0.in_ready), 32'h1);

        // Single code 3 on the 4-cycle instance.
        cycle(1'b0, 1'b1, 1'b1, 3'd3);
        for (int k = 0; k < 5; k++) begin
            check("hold_y", 32'(bus0.y), 32'(hold_y[k]));
            check("hold_ready", 32'(bus0.in_ready), 32'(hold_rd[k]));
            cycle(1'b0, 1'b1, 1'b0, 3'd0);
        end

        // Codes 0 then 7 offered back to back: no zero cycle between them.
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 1'b1, (k <= 4), (k == 0) ? 3'd0 : 3'd7);
            check("b2b_y", 32'(bus0.y), 32'(b2b_y[k]));
        end

        // One code per clock on the 1-cycle instance.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 3'(i));
            check("stream_y", 32'(bus1.y), 32'(8'd1 << i));
            check("stream_ready", 32'(bus1.in_ready), 32'h1);
        end
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 3'd0);

        // Reset in the second hold cycle drops the hold; a later code decodes normally.
        cycle(1'b0, 1'b1, 1'b1, 3'd6);
        check("pre_rst_y", 32'(bus0.y), 32'h40);
        cycle(1'b0, 1'b1, 1'b0, 3'd0);
        cycle(1'b1, 1'b1, 1'b0, 3'd0);
        check("mid_rst_y", 32'(bus0.y), 32'h0);
        check("mid_rst_valid", 32'(bus0.y_valid), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 3'd2);
        check("after_rst_y", 32'(bus0.y), 32'h04);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 3'd0);

        // Enable low blocks accepts.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 3'd4);
            check("en_low_ready", 32'(bus0.in_ready), 32'h0);
            check("en_low_y", 32'(bus0.y), 32'h0);
        end

        // Enable dropped mid-hold: the hold completes, then the block idles.
        cycle(1'b0, 1'b1, 1'b1, 3'd1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b1, 3'd5);
        check("en_drop_idle", 32'(bus0.busy), 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 3'd0);

`ifdef DEC_RETRIGGER_EN
        // Retrigger: code 1 replaced by code 2 one cycle later.
        cycle(1'b0, 1'b1, 1'b1, 3'd1);
        check("retrig_y1", 32'(bus0.y), 32'h02);
        cycle(1'b0, 1'b1, 1'b1, 3'd2);
        for (int k = 0; k < 4; k++) begin
            check("retrig_y2", 32'(bus0.y), 32'h04);
            cycle(1'b0, 1'b1, 1'b0, 3'd0);
        end
        check("retrig_end", 32'(bus0.y), 32'h0);
`endif

        // Randomised tail to exercise mixed enable/valid patterns against the model.
        for (int k = 0; k < 200; k++) begin
            cycle((($urandom_range(0, 39)) == 0), ($urandom_range(0, 7) != 0),
                  $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
        end
        cycle(1'b0, 1'b1, 1'b0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_3to8_pulse.md
Name: decoder_3to8_pulse

Overview:
- Registered 3-to-8 one-hot decoder with valid/ready input handshake and programmable output hold time.
- Each accepted 3-bit code drives exactly one of 8 output lines high for HOLD_CYCLES clocks, then returns all lines low.
- Sits downstream of the team's 8-to-3 encoder path and re-expands its encoded index into a timed one-hot strobe, for example for LED or channel select.

Parameters:
- HOLD_CYCLES, 4, number of clocks each one-hot output stays asserted; legal range 1..255.
- CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when low, no new code is accepted.
- in_valid  in  1  in_code is valid this cycle.
- in_code  in  3  binary index 0..7 to decode.
- in_ready  out  1  decoder can accept a code this cycle (combinational from state/counter/en).
- y  out  8  registered one-hot output; y = 1 << code while holding, else 8'h00.
- y_valid  out  1  registered; high whenever y is nonzero.
- busy  out  1  registered; high in HOLD state.

Behaviour:
- Reset: on a clk edge with rst=1:
  - state := IDLE, y := 8'h00, y_valid := 0, busy := 0, counter := 0.
  - rst has priority over every other event, including mid-hold; a hold in progress is dropped and y is low after that edge.
- Accept: a code is accepted on an edge where in_valid && in_ready. in_code is sampled only on accept; it is ignored otherwise.
- in_ready = en && (state==IDLE || (state==HOLD && cnt==0)).
- FSM states: IDLE, HOLD.
- IDLE:
  - y = 0, y_valid = 0, busy = 0.
  - On accept, the next edge sets y := 1<<in_code, y_valid := 1, busy := 1, cnt := HOLD_CYCLES-1, state := HOLD.
- HOLD:
  - y holds its value; cnt decrements by 1 each edge while cnt != 0.
  - When cnt == 0 and an accept occurs: back-to-back. y := 1<<new code, cnt reloads to HOLD_CYCLES-1, and the FSM stays in HOLD with no gap cycle.
  - When cnt == 0 and no accept occurs: y := 0, y_valid := 0, busy := 0, state := IDLE.
- Latency: accept edge to y asserted is 1 cycle. Each code is visible for exactly HOLD_CYCLES consecutive cycles.
- HOLD_CYCLES = 1: cnt loads 0, so in_ready stays high in HOLD and the block sustains one code per clock.
- en deasserted during HOLD: the current hold completes normally; only new accepts are blocked. The FSM returns to IDLE at the end of the hold.
- Codes are always 3 bits, so there is no illegal input. y is one-hot or zero at every cycle. Counter arithmetic is unsigned and never wraps below 0.

Optional Feature:
- Macro: DEC_RETRIGGER_EN.
- Defined: in_ready = en in all states. An accept during HOLD at any cnt value replaces y with the new one-hot and reloads cnt := HOLD_CYCLES-1 on the next edge. A same-code accept simply extends the hold.
- Undefined: retrigger is only possible at cnt == 0, exactly as in Behaviour.

Test Plan:
- rst=1 for 2 cycles with in_valid=1, in_code=5 -> y=8'h00, y_valid=0, busy=0 throughout. in_ready=1 after rst drops (en=1).
- HOLD_CYCLES=4, accept code 3 at cycle t -> y=8'h08 for cycles t+1..t+4, y=8'h00 at t+5. in_ready=0 at t+1..t+3 and 1 at t+4.
- HOLD_CYCLES=4, codes 0 then 7 offered continuously -> y=8'h01 for 4 cycles immediately followed by y=8'h80 for 4 cycles, with no zero cycle between.
- HOLD_CYCLES=1, codes 0..7 streamed one per clock -> y walks 01,02,04,...,80 on consecutive cycles; in_ready is constantly 1.
- Accept code 6, assert rst at the 2nd hold cycle -> y=8'h00 on the next edge, state IDLE. A code 2 accepted after reset gives y=8'h04.
- en=0 with in_valid=1, code 4 -> in_ready=0 and y stays 0. With DEC_RETRIGGER_EN, code 1 then code 2 one cycle later (HOLD_CYCLES=4) -> y=02 for 1 cycle, then 04 for 4 cycles.
